// File: rtl/cachepool_pkg.sv
// -----------------------------------------------------------------------------
// cachepool_pkg
// Shared CachePool tile definitions for the L1 data cache.
//   - L1 geometry: controller count, total size, associativity.
//   - Derived way size and SPM way-count width used by the runtime L1
//     cache/scratchpad partition controller.
//   - Default parameters for cachepool_l1_partition_ctrl instances.
//   - State encoding for the partition controller FSM.
//   - A helper that builds the cache-enable way mask for a given SPM size.
// -----------------------------------------------------------------------------
package cachepool_pkg;

    // L1 geometry
    localparam int unsigned NumL1CacheCtrl  = 4;
    localparam int unsigned L1Size          = 128;  // KiB, summed over all controllers
    localparam int unsigned L1Associativity = 16;

    // Bytes per way summed across all controllers
    localparam int unsigned L1WayBytes     = L1Size * 1024 / L1Associativity;
    // Enough bits to encode 0..L1Associativity SPM ways
    localparam int unsigned L1SpmWaysWidth = $clog2(L1Associativity + 1);

    // Default instance parameters for cachepool_l1_partition_ctrl
    localparam int unsigned L1PartNumCtrl       = NumL1CacheCtrl;
    localparam int unsigned L1PartNumWays       = L1Associativity;
    localparam int unsigned L1PartWayBytes      = L1WayBytes;
    localparam int unsigned L1PartAddrWidth     = 32;
    localparam int unsigned L1PartResetSpmWays  = 0;
    localparam int unsigned L1PartTimeoutCycles = 4096;

    typedef enum logic [2:0] {
        L1P_IDLE  = 3'd0,
        L1P_DRAIN = 3'd1,
        L1P_FLUSH = 3'd2,
        L1P_APPLY = 3'd3,
        L1P_RESP  = 3'd4
    } l1_part_state_e;

    // SPM ways occupy the highest-indexed ways, so bit i is a cache way
    // exactly when i + spm_ways < num_ways.
    function automatic logic [31:0] l1_way_cache_mask(input int unsigned num_ways,
                                                      input int unsigned spm_ways);
        logic [31:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            mask[i] = ((i + spm_ways) < num_ways);
        end
        return mask;
    endfunction

endpackage

// File: rtl/cachepool_flush_collector.sv
// -----------------------------------------------------------------------------
// cachepool_flush_collector
// Issues a level flush request to every cache controller and collects the
// one-cycle acknowledge pulses in a sticky vector.
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset
//   start_i  : raise all requests and clear the collected acks
//   abort_i  : drop all requests and clear the collected acks (wins over start)
//   ack_i    : per-controller flush done pulse
//   req_o    : per-controller flush request (level)
//   done_o   : every controller has acked, including acks arriving this cycle
// -----------------------------------------------------------------------------
module cachepool_flush_collector #(
    parameter int unsigned NumCtrl = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [NumCtrl-1:0] ack_i,
    output logic [NumCtrl-1:0] req_o,
    output logic               done_o
);

    logic [NumCtrl-1:0] req_q, req_d;
    logic [NumCtrl-1:0] sticky_q, sticky_d;
    logic [NumCtrl-1:0] ack_accept;

    // An ack only counts while its request is still raised; stray pulses on
    // an already-cleared channel are dropped here.
    for (genvar gi = 0; gi < NumCtrl; gi++) begin : g_accept
        assign ack_accept[gi] = ack_i[gi] & req_q[gi];
    end

    always_comb begin
        req_d    = req_q;
        sticky_d = sticky_q;
        if (abort_i) begin
            req_d    = '0;
            sticky_d = '0;
        end else if (start_i) begin
            req_d    = '1;
            sticky_d = '0;
        end else begin
            req_d    = req_q & ~ack_accept;
            sticky_d = sticky_q | ack_accept;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q    <= '0;
            sticky_q <= '0;
        end else begin
            req_q    <= req_d;
            sticky_q <= sticky_d;
        end
    end

    assign req_o = req_q;
    // Looking at this cycle's acks lets the owner move on in the same edge
    // that retires the last request.
    assign done_o = &(sticky_q | ack_accept);

endmodule

// File: rtl/cachepool_l1_partition_ctrl.sv
// -----------------------------------------------------------------------------
// cachepool_l1_partition_ctrl
// Runtime split of the L1 data ways between hardware cache and software
// scratchpad (SPM). A reconfiguration blocks new core traffic, waits for all
// controllers to go idle, flushes every controller, then applies the new way
// mask and SPM window size. A watchdog aborts a stuck drain/flush and keeps
// the old split.
//   clk_i / rst_i     : clock, asynchronous active-high reset
//   cfg_valid_i/_ready_o, cfg_spm_ways_i : request handshake, requested SPM ways
//   rsp_valid_o/_ready_i, rsp_error_o    : response handshake, reject/timeout flag
//   ctrl_busy_i       : per-controller in-flight access pending
//   flush_req_o       : per-controller flush request (level)
//   flush_ack_i       : per-controller flush done pulse
//   block_o           : stall new core requests into L1
//   way_cache_en_o    : 1 = way used as cache
//   spm_size_o        : SPM window size in bytes
// -----------------------------------------------------------------------------
module cachepool_l1_partition_ctrl
    import cachepool_pkg::*;
#(
    parameter int unsigned NumCtrl       = L1PartNumCtrl,
    parameter int unsigned NumWays       = L1PartNumWays,
    parameter int unsigned WayBytes      = L1PartWayBytes,
    parameter int unsigned AddrWidth     = L1PartAddrWidth,
    parameter int unsigned ResetSpmWays  = L1PartResetSpmWays,
    parameter int unsigned TimeoutCycles = L1PartTimeoutCycles
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cfg_valid_i,
    output logic                           cfg_ready_o,
    input  logic [$clog2(NumWays+1)-1:0]   cfg_spm_ways_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic                           rsp_error_o,
    input  logic [NumCtrl-1:0]             ctrl_busy_i,
    output logic [NumCtrl-1:0]             flush_req_o,
    input  logic [NumCtrl-1:0]             flush_ack_i,
    output logic                           block_o,
    output logic [NumWays-1:0]             way_cache_en_o,
    output logic [AddrWidth-1:0]           spm_size_o
);

    localparam int unsigned SpmW = $clog2(NumWays + 1);
    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0]      CntLast       = CntW'(TimeoutCycles - 1);
    localparam logic [31:0]          ResetMaskFull = l1_way_cache_mask(NumWays, ResetSpmWays);
    localparam logic [NumWays-1:0]   ResetMask     = ResetMaskFull[NumWays-1:0];
    localparam logic [AddrWidth-1:0] ResetSpmSize  = AddrWidth'(ResetSpmWays) * AddrWidth'(WayBytes);
    localparam logic [SpmW-1:0]      ResetSpmWaysV = SpmW'(ResetSpmWays);

    l1_part_state_e       state_q, state_d;
    logic [SpmW-1:0]      req_ways_q, req_ways_d;   // latched request
    logic [SpmW-1:0]      cur_ways_q, cur_ways_d;   // split currently in force
    logic [NumWays-1:0]   way_en_q, way_en_d;
    logic [AddrWidth-1:0] spm_size_q, spm_size_d;
    logic                 block_q, block_d;
    logic                 err_q, err_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    logic                 flush_start;
    logic                 flush_abort;
    logic                 flush_done;
    logic                 timeout;
    logic [31:0]          req_ways_ext;
    logic [NumWays-1:0]   way_mask_new;
    logic [AddrWidth-1:0] spm_size_new;

    cachepool_flush_collector #(
        .NumCtrl (NumCtrl)
    ) i_flush_collector (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (flush_start),
        .abort_i (flush_abort),
        .ack_i   (flush_ack_i),
        .req_o   (flush_req_o),
        .done_o  (flush_done)
    );

    // New split derived from the latched request; only loaded in APPLY.
    assign req_ways_ext = 32'(req_ways_q);
    for (genvar gi = 0; gi < NumWays; gi++) begin : g_way_mask
        assign way_mask_new[gi] = ((32'(gi) + req_ways_ext) < 32'(NumWays));
    end
    assign spm_size_new = AddrWidth'(req_ways_q) * AddrWidth'(WayBytes);

    assign timeout = (cnt_q == CntLast);

    always_comb begin
        state_d     = state_q;
        req_ways_d  = req_ways_q;
        cur_ways_d  = cur_ways_q;
        way_en_d    = way_en_q;
        spm_size_d  = spm_size_q;
        block_d     = block_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        flush_start = 1'b0;
        flush_abort = 1'b0;

        unique case (state_q)
            L1P_IDLE: begin
                if (cfg_valid_i) begin
                    req_ways_d = cfg_spm_ways_i;
                    if (32'(cfg_spm_ways_i) > NumWays) begin
                        // Out-of-range request: reject without touching anything
                        err_d   = 1'b1;
                        state_d = L1P_RESP;
                    end else if (cfg_spm_ways_i == cur_ways_q) begin
                        // Nothing to change, so no need to disturb the caches
                        err_d   = 1'b0;
                        state_d = L1P_RESP;
                    end else begin
                        err_d   = 1'b0;
                        block_d = 1'b1;
                        cnt_d   = '0;
                        state_d = L1P_DRAIN;
                    end
                end
            end

            L1P_DRAIN: begin
                cnt_d = cnt_q + CntW'(1);
                if (timeout) begin
                    flush_abort = 1'b1;
                    block_d     = 1'b0;
                    err_d       = 1'b1;
                    state_d     = L1P_RESP;
                end else if (ctrl_busy_i == '0) begin
                    flush_start = 1'b1;
                    state_d     = L1P_FLUSH;
                end
            end

            L1P_FLUSH: begin
                cnt_d = cnt_q + CntW'(1);
                if (timeout) begin
                    // Give up on the flush; the old split stays in force
                    flush_abort = 1'b1;
                    block_d     = 1'b0;
                    err_d       = 1'b1;
                    state_d     = L1P_RESP;
                end else if (flush_done) begin
                    state_d = L1P_APPLY;
                end
            end

            L1P_APPLY: begin
                cur_ways_d = req_ways_q;
                way_en_d   = way_mask_new;
                spm_size_d = spm_size_new;
                block_d    = 1'b0;
                state_d    = L1P_RESP;
            end

            L1P_RESP: begin
                if (rsp_ready_i) begin
                    err_d   = 1'b0;
                    state_d = L1P_IDLE;
                end
            end

            default: begin
                state_d = L1P_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= L1P_IDLE;
            req_ways_q <= ResetSpmWaysV;
            cur_ways_q <= ResetSpmWaysV;
            way_en_q   <= ResetMask;
            spm_size_q <= ResetSpmSize;
            block_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_ways_q <= req_ways_d;
            cur_ways_q <= cur_ways_d;
            way_en_q   <= way_en_d;
            spm_size_q <= spm_size_d;
            block_q    <= block_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign cfg_ready_o    = (state_q == L1P_IDLE);
    assign rsp_valid_o    = (state_q == L1P_RESP);
    assign rsp_error_o    = err_q;
    assign block_o        = block_q;
    assign way_cache_en_o = way_en_q;
    assign spm_size_o     = spm_size_q;

endmodule

// File: tb/tb_cachepool_l1_partition_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cachepool_l1_partition_ctrl
// Self-checking bench: directed cases plus randomized reconfigurations. The
// expected response timing and per-cycle flush/block behaviour are derived
// from drain length, per-channel ack delays and the timeout bound.
// -----------------------------------------------------------------------------
module tb_cachepool_l1_partition_ctrl;

    localparam int NC  = 4;
    localparam int NW  = 16;
    localparam int WB  = 8192;
    localparam int AW  = 32;
    localparam int RSW = 4;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [4:0]    cfg_spm_ways_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic          rsp_error_o;
    logic [NC-1:0] ctrl_busy_i;
    logic [NC-1:0] flush_req_o;
    logic [NC-1:0] flush_ack_i;
    logic          block_o;
    logic [NW-1:0] way_cache_en_o;
    logic [AW-1:0] spm_size_o;

    always #5 clk = ~clk;

    cachepool_l1_partition_ctrl #(
        .NumCtrl       (NC),
        .NumWays       (NW),
        .WayBytes      (WB),
        .AddrWidth     (AW),
        .ResetSpmWays  (RSW),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_spm_ways_i (cfg_spm_ways_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_error_o    (rsp_error_o),
        .ctrl_busy_i    (ctrl_busy_i),
        .flush_req_o    (flush_req_o),
        .flush_ack_i    (flush_ack_i),
        .block_o        (block_o),
        .way_cache_en_o (way_cache_en_o),
        .spm_size_o     (spm_size_o)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int txn_id       = 0;
    int cur_ways;                 // split the model believes is in force
    int ack_dly [NC];             // cycles from first seeing a request to its ack
    logic [NC-1:0] never_ack;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NW-1:0] exp_mask(input int spm);
        logic [NW-1:0] m;
        for (int i = 0; i < NW; i++) m[i] = (i < NW - spm);
        return m;
    endfunction

    // Controller model: acks each flush request once, ack_dly cycles after
    // first seeing it raised.
    int            resp_cnt [NC];
    logic [NC-1:0] resp_pend;
    logic [NC-1:0] resp_done;
    initial begin
        flush_ack_i = '0;
        resp_pend   = '0;
        resp_done   = '0;
        forever begin
            @(posedge clk); #1;
            for (int c = 0; c < NC; c++) begin
                flush_ack_i[c] = 1'b0;
                if (rst_i) begin
                    resp_pend[c] = 1'b0;
                    resp_done[c] = 1'b0;
                end else if (resp_pend[c]) begin
                    resp_cnt[c]--;
                    if (resp_cnt[c] == 0) begin
                        flush_ack_i[c] = 1'b1;
                        resp_pend[c]   = 1'b0;
                        resp_done[c]   = 1'b1;
                    end
                end else if (flush_req_o[c] && !resp_done[c] && !never_ack[c]) begin
                    resp_pend[c] = 1'b1;
                    resp_cnt[c]  = ack_dly[c];
                end else if (!flush_req_o[c]) begin
                    resp_done[c] = 1'b0;
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_cfg_ready"}, 64'(cfg_ready_o), 64'd1);
        check_eq({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        check_eq({tag, "_rsp_error"}, 64'(rsp_error_o), 64'd0);
        check_eq({tag, "_flush_req"}, 64'(flush_req_o), 64'd0);
        check_eq({tag, "_block"},     64'(block_o),     64'd0);
        check_eq({tag, "_way_mask"},  64'(way_cache_en_o), 64'h0FFF);
        check_eq({tag, "_spm_size"},  64'(spm_size_o),  64'h8000);
    endtask

    // One reconfiguration. Cycle k is the k-th cycle after the handshake edge.
    // Drain lasts busy_cycles+1 cycles, flush lasts (slowest ack delay)+1
    // cycles, then one apply cycle; the watchdog ends drain+flush after TO
    // cycles. Rejected and no-change requests answer in cycle 1.
    task automatic run_txn(input int ways, input int busy_cycles,
                           input logic [NC-1:0] busy_val, input int rdy_wait);
        bit   inv, same, flows, tmo;
        int   d, f, r;
        logic exp_err;
        logic [NC-1:0] exp_req;
        inv   = (ways > NW);
        same  = (ways == cur_ways);
        flows = !inv && !same;
        d     = busy_cycles + 1;
        f     = 0;
        for (int c = 0; c < NC; c++) begin
            if (never_ack[c]) f = 1000;
            else if (ack_dly[c] + 1 > f) f = ack_dly[c] + 1;
        end
        tmo = flows && (d + f >= TO);
        if (!flows)   begin r = 1;         exp_err = inv;  end
        else if (tmo) begin r = TO + 1;    exp_err = 1'b1; end
        else          begin r = d + f + 2; exp_err = 1'b0; end

        check_eq("cfg_ready_before", 64'(cfg_ready_o), 64'd1);
        cfg_valid_i    = 1'b1;
        cfg_spm_ways_i = 5'(ways);
        ctrl_busy_i    = (busy_cycles > 0) ? busy_val : '0;
        @(posedge clk); #1;
        cfg_valid_i = 1'b0;

        for (int k = 1; k <= r; k++) begin
            ctrl_busy_i = (k <= busy_cycles) ? busy_val : '0;
            for (int c = 0; c < NC; c++) begin
                exp_req[c] = flows && (k >= d + 1) && (k <= r - 1) &&
                             (never_ack[c] || (k <= d + 1 + ack_dly[c]));
            end
            check_eq($sformatf("rsp_valid_c%0d", k), 64'(rsp_valid_o), 64'(k == r));
            check_eq($sformatf("block_c%0d", k), 64'(block_o), 64'(flows && (k < r)));
            check_eq($sformatf("cfg_ready_c%0d", k), 64'(cfg_ready_o), 64'd0);
            check_eq($sformatf("flush_req_c%0d", k), 64'(flush_req_o), 64'(exp_req));
            if (k < r) begin
                @(posedge clk); #1;
            end
        end

        if (flows && !tmo) cur_ways = ways;
        check_eq("rsp_error", 64'(rsp_error_o), 64'(exp_err));
        check_eq("way_mask", 64'(way_cache_en_o), 64'(exp_mask(cur_ways)));
        check_eq("spm_size", 64'(spm_size_o), 64'(cur_ways * WB));

        rsp_ready_i = 1'b0;
        for (int w = 0; w < rdy_wait; w++) begin
            @(posedge clk); #1;
            check_eq("rsp_hold_valid", 64'(rsp_valid_o), 64'd1);
            check_eq("rsp_hold_error", 64'(rsp_error_o), 64'(exp_err));
            check_eq("rsp_hold_flush", 64'(flush_req_o), 64'd0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        check_eq("idle_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check_eq("idle_cfg_ready", 64'(cfg_ready_o), 64'd1);
        check_eq("idle_block",     64'(block_o),     64'd0);
        check_eq("idle_way_mask",  64'(way_cache_en_o), 64'(exp_mask(cur_ways)));

        txn_id++;
        $display("[TB] txn %0d ways=%0d busy=%0d err=%0d rsp_cycle=%0d mask=%04h",
                 txn_id, ways, busy_cycles, exp_err, r, way_cache_en_o);
    endtask

    task automatic set_acks(input int d0, input int d1, input int d2, input int d3,
                            input logic [NC-1:0] never);
        ack_dly[0] = d0;
        ack_dly[1] = d1;
        ack_dly[2] = d2;
        ack_dly[3] = d3;
        never_ack  = never;
    endtask

    initial begin
        rst_i          = 1'b1;
        cfg_valid_i    = 1'b0;
        cfg_spm_ways_i = '0;
        rsp_ready_i    = 1'b0;
        ctrl_busy_i    = '0;
        set_acks(1, 1, 1, 1, '0);
        cur_ways       = RSW;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("in_reset");
        rst_i = 1'b0;
        @(posedge clk); #1;
        check_reset_values("after_reset");

        // Minimum-latency reconfiguration
        run_txn(8, 0, '0, 0);
        // Long drain on ctrl 2, staggered acks 3, then 0+2 together, then 1
        set_acks(2, 3, 2, 1, '0);
        run_txn(6, 10, 4'b0100, 1);
        // Out of range request, then a no-change request
        set_acks(1, 1, 1, 1, '0);
        run_txn(17, 0, '0, 2);
        run_txn(cur_ways, 0, '0, 0);
        // Controller 1 never acks: watchdog fires, old split kept
        set_acks(1, 1, 1, 1, 4'b0010);
        run_txn(3, 0, '0, 1);
        // Upper boundary: everything to SPM, then everything back to cache
        set_acks(1, 1, 1, 1, '0);
        run_txn(16, 0, '0, 0);
        run_txn(0, 1, 4'b1001, 0);

        for (int i = 0; i < 40; i++) begin
            set_acks($urandom_range(1, 4), $urandom_range(1, 4),
                     $urandom_range(1, 4), $urandom_range(1, 4), '0);
            run_txn($urandom_range(0, 18), $urandom_range(0, 3),
                    4'($urandom_range(1, 15)), $urandom_range(0, 2));
        end

        // Move away from the reset split, then reset in the middle of a flush
        set_acks(1, 1, 1, 1, '0);
        run_txn((cur_ways == 9) ? 10 : 9, 0, '0, 0);
        set_acks(1, 1, 1, 1, 4'b1111);
        cfg_valid_i    = 1'b1;
        cfg_spm_ways_i = 5'd2;
        @(posedge clk); #1;            // drain cycle
        cfg_valid_i = 1'b0;
        @(posedge clk); #1;            // first flush cycle
        check_eq("midflush_req",   64'(flush_req_o), 64'hF);
        check_eq("midflush_block", 64'(block_o),     64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(posedge clk); #1;
        rst_i    = 1'b0;
        cur_ways = RSW;
        check_reset_values("post_async_reset");

        set_acks(1, 2, 1, 2, '0);
        run_txn(12, 2, 4'b0011, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
